// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC bit packer.
package cavlc_pkg;

    localparam int unsigned WORD_W       = 16;
    localparam int unsigned MAX_CODE_LEN = 16;
    localparam int unsigned ACC_W        = 32;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned LEN_W        = 5;

    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DONE
    } packer_state_t;

    // Lengths above the widest codeword saturate rather than wrap.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : len;
    endfunction

endpackage

// File: rtl/bit_packer_out_reg.sv
// Output holding register for packed words with valid/ready handshake.
module bit_packer_out_reg
    import cavlc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_free
);

    logic              r_valid;
    logic [WORD_W-1:0] r_data;

    // A reload in the same cycle as acceptance keeps valid high with new data.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_free  = ~r_valid | i_ready;

endmodule

// File: rtl/bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into 16-bit words, with flush.
// Define BIT_PACKER_STATS_EN to add the WordCount/BitCount statistics outputs.
module bit_packer
    import cavlc_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    CodeValid,
    input  logic [MAX_CODE_LEN-1:0] CodeBits,
    input  logic [LEN_W-1:0]        CodeLen,
    output logic                    CodeReady,
    input  logic                    FlushReq,
    output logic                    FlushDone,
    output logic                    WordValid,
    output logic [WORD_W-1:0]       WordData,
    input  logic                    WordReady
`ifdef BIT_PACKER_STATS_EN
    ,
    output logic [31:0]             WordCount,
    output logic [31:0]             BitCount
`endif
);

    packer_state_t           r_state;
    packer_state_t           w_state_nxt;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_acc_nxt;
    logic [ACC_W-1:0]        w_acc_shift;
    logic [ACC_W-1:0]        w_code_pos;
    logic [CNT_W-1:0]        r_bitcnt;
    logic [CNT_W-1:0]        w_bitcnt_nxt;
    logic [CNT_W-1:0]        w_bitcnt_shift;
    logic                    r_flush_done;
    logic                    w_flush_done_nxt;
    logic                    w_clear;
    logic                    w_out_free;
    logic                    w_xfer;
    logic                    w_accept;
    logic [LEN_W-1:0]        w_len;
    logic [LEN_W-1:0]        w_align;
    logic [MAX_CODE_LEN-1:0] w_mask;
    logic [MAX_CODE_LEN-1:0] w_code;

    assign w_clear   = Reset | ~Enable;
    assign w_xfer    = (r_bitcnt >= CNT_WORD) & w_out_free;
    assign CodeReady = ~Reset & Enable & (r_state == RUN) &
                       ((r_bitcnt < CNT_WORD) | w_xfer);
    assign w_accept  = CodeValid & CodeReady;

    assign w_len   = clamp_len(CodeLen);
    assign w_mask  = MAX_CODE_LEN'((32'd1 << w_len) - 32'd1);
    assign w_code  = CodeBits & w_mask;
    assign w_align = LEN_W'(MAX_CODE_LEN) - w_len;

    // Shift out the transferred word first so the append lands at BitCnt-16.
    assign w_acc_shift    = w_xfer ? {r_acc[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}} : r_acc;
    assign w_bitcnt_shift = w_xfer ? (r_bitcnt - CNT_WORD) : r_bitcnt;

    // Left-justify the code to bit 31, then slide it down to the fill position.
    assign w_code_pos = ({w_code, {(ACC_W-MAX_CODE_LEN){1'b0}}} << w_align) >> w_bitcnt_shift;

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = w_acc_shift;
        w_bitcnt_nxt     = w_bitcnt_shift;
        w_flush_done_nxt = 1'b0;

        if (w_accept) begin
            w_acc_nxt    = w_acc_shift | w_code_pos;
            w_bitcnt_nxt = w_bitcnt_shift + CNT_W'(w_len);
        end

        unique case (r_state)
            RUN: begin
                if (FlushReq) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if ((r_bitcnt == '0) && !WordValid) begin
                    w_state_nxt      = DONE;
                    w_flush_done_nxt = 1'b1;
                end else if ((r_bitcnt != '0) && (r_bitcnt < CNT_WORD)) begin
                    // Low accumulator bits are already zero, so padding is just a count bump.
                    w_bitcnt_nxt = CNT_WORD;
                end
            end
            DONE: begin
                if (!FlushReq) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_clear) begin
            r_state      <= RUN;
            r_acc        <= '0;
            r_bitcnt     <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    assign FlushDone = r_flush_done;

    bit_packer_out_reg u_out_reg (
        .i_clk       (Clk),
        .i_clear     (w_clear),
        .i_load      (w_xfer),
        .i_load_data (r_acc[ACC_W-1:ACC_W-WORD_W]),
        .i_ready     (WordReady),
        .o_valid     (WordValid),
        .o_data      (WordData),
        .o_free      (w_out_free)
    );

`ifdef BIT_PACKER_STATS_EN
    logic [31:0] r_word_count;
    logic [31:0] r_bit_count;

    always_ff @(posedge Clk) begin
        if (w_clear) begin
            r_word_count <= '0;
            r_bit_count  <= '0;
        end else begin
            if (WordValid && WordReady) begin
                r_word_count <= r_word_count + 32'd1;
            end
            if (w_accept) begin
                r_bit_count <= r_bit_count + 32'(w_len);
            end
        end
    end

    assign WordCount = r_word_count;
    assign BitCount  = r_bit_count;
`endif

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 The module SHALL have the port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-002 The module SHALL have the port Reset, input, 1 bit, a synchronous active-high reset.
REQ-003 The module SHALL have the port Enable, input, 1 bit; while it is low, all state is synchronously cleared as for Reset.
REQ-004 The module SHALL have the port CodeValid, input, 1 bit; it marks a codeword as offered.
REQ-005 The module SHALL have the port CodeBits, input, 16 bits; the codeword is right-aligned and is emitted MSB-first.
REQ-006 The module SHALL have the port CodeLen, input, 5 bits; it gives the codeword length, 0 to 16.
REQ-007 The module SHALL have the port CodeReady, output, 1 bit; it shows the packer can accept a codeword this cycle.
REQ-008 The module SHALL have the port FlushReq, input, 1 bit; it is a level request to pad and drain the final partial word.
REQ-009 The module SHALL have the port FlushDone, output, 1 bit; it is a one-cycle pulse when the flush is complete.
REQ-010 The module SHALL have the port WordValid, output, 1 bit; it marks a packed word as present.
REQ-011 The module SHALL have the port WordData, output, 16 bits; it carries the packed word, first bit in bit 15.
REQ-012 The module SHALL have the port WordReady, input, 1 bit; it shows the downstream sink accepts the word.

Function
REQ-013 The packer SHALL hold a 32-bit MSB-aligned accumulator Acc and a 6-bit fill count BitCnt in the range 0 to 31.
REQ-014 A code SHALL be accepted when CodeValid and CodeReady are both high: CodeBits[CodeLen-1:0] is appended to Acc at position BitCnt, and BitCnt increases by CodeLen.
REQ-015 Bits of CodeBits above CodeLen-1 SHALL be ignored (masked); CodeLen=0 SHALL be accepted with no change to Acc or BitCnt.
REQ-016 A CodeLen value above 16 SHALL be treated as 16.
REQ-017 XferNow SHALL equal (BitCnt>=16) AND (!WordValid OR WordReady).
REQ-018 On XferNow, Acc[31:16] SHALL load WordData, WordValid SHALL be set, Acc SHALL shift left by 16, and BitCnt SHALL decrease by 16.
REQ-019 CodeReady SHALL equal Enable AND (state==RUN) AND (BitCnt<16 OR XferNow).
REQ-020 A simultaneous transfer and accept SHALL apply the shift first, then the append at position BitCnt-16.
REQ-021 The packer SHALL sustain one 16-bit code per cycle.
REQ-022 Latency SHALL be as follows: the code that completes a word is accepted at edge N, WordValid is high from edge N+1 if the output register is free, otherwise it is stalled.
REQ-023 WordValid SHALL hold, with WordData stable, until WordReady is seen high; WordValid clears on acceptance unless XferNow reloads it in the same cycle.
REQ-024 The state machine SHALL have the states RUN, FLUSH, and DONE.
REQ-025 RUN SHALL move to FLUSH when FlushReq is high; the code accepted in that same cycle, if any, is still appended.
REQ-026 In FLUSH, CodeReady SHALL be 0; if 0<BitCnt<16, the packer pads with zeros by setting BitCnt to 16 (Acc low bits are already zero), then transfers normally.
REQ-027 FLUSH SHALL move to DONE when BitCnt==0 and WordValid==0.
REQ-028 DONE SHALL pulse FlushDone for one cycle, then return to RUN when FlushReq is low, else stay in DONE.
REQ-029 A flush with BitCnt==0 and WordValid==0 SHALL reach DONE in 1 cycle and emit no word.
REQ-030 Enable or Reset going low or high respectively mid-operation SHALL discard all pending bits and any held word, with no FlushDone.

Reset
REQ-031 Reset SHALL set Acc=0, BitCnt=0, state=RUN, WordValid=0, WordData=0, FlushDone=0, and CodeReady=0 during reset.
REQ-032 Clearing by Enable low SHALL be identical to Reset, and CodeReady SHALL be 0 while Enable is low.

Configuration
REQ-033 With BIT_PACKER_STATS_EN defined, the module SHALL add the outputs WordCount[31:0] (words accepted by the sink) and BitCount[31:0] (sum of accepted CodeLen, pad excluded).
REQ-034 WordCount and BitCount SHALL wrap modulo 2^32 and be cleared by Reset or Enable low.
REQ-035 Without BIT_PACKER_STATS_EN, those ports and counters SHALL be absent, with no change to other behaviour.

Structure
REQ-036 The shared package cavlc_pkg SHALL hold WORD_W=16, MAX_CODE_LEN=16, ACC_W=32, and the typedef packer_state_t {RUN, FLUSH, DONE}.
REQ-037 The output holding register and valid/ready logic SHALL be the sub-module bit_packer_out_reg.

Verification
REQ-038 The bench SHALL apply codes (0b101, 3), (0x1FFF, 13) with WordReady=1 and check WordData=0xBFFF, WordValid at edge N+1, and BitCnt=0.
REQ-039 The bench SHALL apply eight 16-bit codes 0x0001..0x0008 back-to-back with WordReady=1 and check eight words 0x0001..0x0008 and CodeReady constantly 1.
REQ-040 The bench SHALL apply code (0b11, 2) then FlushReq and check WordData=0xC000, followed one cycle later by a FlushDone pulse.
REQ-041 The bench SHALL hold WordReady=0 and fill the packer, and check CodeReady drops once BitCnt>=16, WordData stays stable, and no bits are lost after WordReady=1.
REQ-042 The bench SHALL apply code (0xFFFF, 4) and check only 0xF is appended; it SHALL apply CodeLen=0 and check BitCnt is unchanged.
REQ-043 The bench SHALL assert Reset with BitCnt=9 and WordValid=1 and check all outputs are 0 next cycle; with BIT_PACKER_STATS_EN, it SHALL check that WordCount and BitCount are 0.
